dmem_slave: RTL and testbench

DMEM_SLAVE -- requirements
Module: dmem_slave

---
 rtl/dmem_slave_pkg.sv | 20 ++
 rtl/dmem_slave_if.sv | 30 +++
 rtl/dmem_lane_align.sv | 61 ++++++
 rtl/dmem_slave.sv | 163 ++++++++++++++++
 tb/tb_dmem_slave.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_slave_pkg.sv
// Shared definitions for the data-memory slave: bus widths, access-width
// encodings and the transaction FSM states.
package dmem_slave_pkg;

  localparam int XLEN      = 32;
  localparam int ADDR_SIZE = 32;

  typedef enum logic [1:0] {
    WIDTH_WORD = 2'b00,
    WIDTH_BYTE = 2'b01,
    WIDTH_HALF = 2'b10
  } width_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

endpackage

// File: rtl/dmem_slave_if.sv
// Request/response bus between the pipeline (master) and the data-memory slave.
interface dmem_slave_if;
  import dmem_slave_pkg::*;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_we;
  logic [ADDR_SIZE-1:0] req_addr;
  logic [XLEN-1:0]      req_wdata;
  width_e               req_lwhb;
  width_e               req_swhb;
  logic                 req_lunsigned;
  logic                 resp_valid;
  logic                 resp_ready;
  logic [XLEN-1:0]      resp_rdata;
  logic                 resp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_lwhb, req_swhb,
           req_lunsigned, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_lwhb, req_swhb,
           req_lunsigned, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores and extract/extend for loads; misaligned
// offsets are force-aligned here, the trap decision is left to the caller.
module dmem_lane_align
  import dmem_slave_pkg::*;
(
  input  logic            we,
  input  logic [1:0]      addrLo,
  input  width_e          lwhb,
  input  width_e          swhb,
  input  logic            lunsigned,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rword,
  output logic [3:0]      byteEn,
  output logic [XLEN-1:0] wrLanes,
  output logic [XLEN-1:0] ldData,
  output logic            misaligned
);

  function automatic logic [XLEN-1:0] extByte(input logic signed [7:0] b, input logic uns);
    return uns ? {24'b0, b} : XLEN'(b);
  endfunction

  function automatic logic [XLEN-1:0] extHalf(input logic signed [15:0] h, input logic uns);
    return uns ? {16'b0, h} : XLEN'(h);
  endfunction

  width_e          width;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  always_comb begin
    width      = we ? swhb : lwhb;
    misaligned = 1'b0;
    off        = addrLo;
    byteEn     = 4'b1111;
    wrLanes    = wdata;
    case (width)
      WIDTH_BYTE: begin
        byteEn  = 4'b0001 << off;
        wrLanes = {4{wdata[7:0]}};
      end
      WIDTH_HALF: begin
        misaligned = addrLo[0];
        off[0]     = 1'b0;
        byteEn     = 4'b0011 << off;
        wrLanes    = {2{wdata[15:0]}};
      end
      default: begin
        misaligned = (addrLo != 2'b00);
        off        = 2'b00;
      end
    endcase
    shifted = rword >> {off, 3'b000};
    case (width)
      WIDTH_BYTE: ldData = extByte(shifted[7:0], lunsigned);
      WIDTH_HALF: ldData = extHalf(shifted[15:0], lunsigned);
      default:    ldData = shifted;
    endcase
  end

endmodule

// File: rtl/dmem_slave.sv
// Single-outstanding data-memory slave with a fixed WAIT_CYCLES response delay.
// Optional misaligned-access trap: define DMEM_SLAVE_MISALIGN_TRAP_EN.
module dmem_slave
  import dmem_slave_pkg::*;
#(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic         clk,
  input  logic         reset,
  dmem_slave_if.slave  bus
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

  state_e               state;
  logic [3:0]           cnt;
  logic                 reqReady;
  logic                 respValid;
  logic [XLEN-1:0]      respRdata;
  logic                 respErr;

  logic                 we_p0;
  logic [ADDR_SIZE-1:0] addr_p0;
  logic [XLEN-1:0]      wdata_p0;
  width_e               lwhb_p0;
  width_e               swhb_p0;
  logic                 lunsigned_p0;

  logic [XLEN-1:0]      mem [DEPTH_WORDS];

  // With zero wait the access completes on the accept edge, so the live
  // request fields must feed the datapath while still in IDLE.
  logic                 inIdle;
  logic                 curWe;
  logic [ADDR_SIZE-1:0] curAddr;
  logic [XLEN-1:0]      curWdata;
  width_e               curLwhb;
  width_e               curSwhb;
  logic                 curLunsigned;
  logic [IDX_W-1:0]     idx;
  logic                 unusedAddrBits;

  assign inIdle       = (state == IDLE);
  assign curWe        = inIdle ? bus.req_we        : we_p0;
  assign curAddr      = inIdle ? bus.req_addr      : addr_p0;
  assign curWdata     = inIdle ? bus.req_wdata     : wdata_p0;
  assign curLwhb      = inIdle ? bus.req_lwhb      : lwhb_p0;
  assign curLunsigned = inIdle ? bus.req_lunsigned : lunsigned_p0;
  assign curSwhb      = inIdle ? bus.req_swhb      : swhb_p0;
  assign idx          = curAddr[IDX_W+1:2];
  assign unusedAddrBits = ^curAddr[ADDR_SIZE-1:IDX_W+2];

  logic [3:0]      byteEn;
  logic [XLEN-1:0] wrLanes;
  logic [XLEN-1:0] ldData;
  logic            misaligned;
  logic            trap;

  dmem_lane_align u_align (
    .we         (curWe),
    .addrLo     (curAddr[1:0]),
    .lwhb       (curLwhb),
    .swhb       (curSwhb),
    .lunsigned  (curLunsigned),
    .wdata      (curWdata),
    .rword      (mem[idx]),
    .byteEn     (byteEn),
    .wrLanes    (wrLanes),
    .ldData     (ldData),
    .misaligned (misaligned)
  );

`ifdef DMEM_SLAVE_MISALIGN_TRAP_EN
  assign trap = misaligned;
`else
  assign trap = 1'b0;
`endif

  logic accept;
  logic enterResp;
  logic memWe;

  assign accept    = bus.req_valid & reqReady;
  assign enterResp = (inIdle && accept && (WAIT_CYCLES == 0)) ||
                     ((state == WAIT) && (cnt == 4'd0));
  assign memWe     = enterResp & curWe & ~trap;

  // p0: request capture at the accept edge
  always_ff @(posedge clk) begin
    if (accept) begin
      we_p0        <= bus.req_we;
      addr_p0      <= bus.req_addr;
      wdata_p0     <= bus.req_wdata;
      lwhb_p0      <= bus.req_lwhb;
      swhb_p0      <= bus.req_swhb;
      lunsigned_p0 <= bus.req_lunsigned;
    end
  end

  always_ff @(posedge clk) begin
    if (memWe) begin
      for (int b = 0; b < 4; b++) begin
        if (byteEn[b]) mem[idx][8*b +: 8] <= wrLanes[8*b +: 8];
      end
    end
  end

  // p1: transaction FSM and registered response
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      reqReady  <= 1'b1;
      respValid <= 1'b0;
      respRdata <= '0;
      respErr   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            reqReady <= 1'b0;
            if (WAIT_CYCLES == 0) begin
              state <= RESP;
            end else begin
              state <= WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        WAIT: begin
          if (cnt == 4'd0) state <= RESP;
          else             cnt   <= cnt - 4'd1;
        end
        RESP: begin
          if (bus.resp_ready) begin
            state     <= IDLE;
            reqReady  <= 1'b1;
            respValid <= 1'b0;
            respRdata <= '0;
            respErr   <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          reqReady <= 1'b1;
        end
      endcase
      if (enterResp) begin
        respValid <= 1'b1;
        respRdata <= (curWe || trap) ? '0 : ldData;
        respErr   <= trap;
      end
    end
  end

  assign bus.req_ready  = reqReady;
  assign bus.resp_valid = respValid;
  assign bus.resp_rdata = respRdata;
  assign bus.resp_err   = respErr;

endmodule

// File: tb/tb_dmem_slave.sv
// Directed bench for dmem_slave: one instance with WAIT_CYCLES=2, one with 0.
module tb_dmem_slave;
  import dmem_slave_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   nRun = 0;
  int   nFail = 0;

  always #5 clk = ~clk;

  dmem_slave_if bus ();
  dmem_slave_if bus0 ();

  dmem_slave #(.WAIT_CYCLES(2), .DEPTH_WORDS(1024)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );
  dmem_slave #(.WAIT_CYCLES(0), .DEPTH_WORDS(1024)) dut0 (
    .clk(clk), .reset(reset), .bus(bus0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nRun++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction on the WAIT_CYCLES=2 instance; called one cycle-phase after a posedge.
  task automatic xact(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                      input width_e w, input logic uns,
                      output logic [31:0] rdata, output logic err, output int lat);
    bus.req_we = we; bus.req_addr = addr; bus.req_wdata = wdata;
    bus.req_lwhb = w; bus.req_swhb = w; bus.req_lunsigned = uns;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    lat = 1;
    while (!bus.resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rdata = bus.resp_rdata; err = bus.resp_err;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.resp_ready = 1'b0;
  endtask

  task automatic xact0(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] rdata, output int lat);
    bus0.req_we = we; bus0.req_addr = addr; bus0.req_wdata = wdata;
    bus0.req_lwhb = WIDTH_WORD; bus0.req_swhb = WIDTH_WORD; bus0.req_lunsigned = 1'b0;
    bus0.req_valid = 1'b1;
    @(posedge clk); #1;
    bus0.req_valid = 1'b0;
    lat = 1;
    while (!bus0.resp_valid && lat < 20) begin
      @(posedge clk); #1; lat++;
    end
    rdata = bus0.resp_rdata;
    bus0.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus0.resp_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    bus.req_valid = 0; bus.req_we = 0; bus.req_addr = 0; bus.req_wdata = 0;
    bus.req_lwhb = WIDTH_WORD; bus.req_swhb = WIDTH_WORD; bus.req_lunsigned = 0;
    bus.resp_ready = 0;
    bus0.req_valid = 0; bus0.req_we = 0; bus0.req_addr = 0; bus0.req_wdata = 0;
    bus0.req_lwhb = WIDTH_WORD; bus0.req_swhb = WIDTH_WORD; bus0.req_lunsigned = 0;
    bus0.resp_ready = 0;

    #12;
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'h0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;

    // Word store then load, with latency
    xact(1, 32'h10, 32'hDEADBEEF, WIDTH_WORD, 0, rd, er, lat);
    chk("st_word_lat", 32'(lat), 32'd3);
    chk("st_word_rdata", rd, 32'h0);
    chk("st_word_err", 32'(er), 32'd0);
    xact(0, 32'h10, 0, WIDTH_WORD, 0, rd, er, lat);
    chk("ld_word_lat", 32'(lat), 32'd3);
    chk("ld_word", rd, 32'hDEADBEEF);

    // Byte store and extensions
    xact(1, 32'h13, 32'h00000080, WIDTH_BYTE, 0, rd, er, lat);
    xact(0, 32'h13, 0, WIDTH_BYTE, 0, rd, er, lat);
    chk("ld_byte_s", rd, 32'hFFFFFF80);
    xact(0, 32'h13, 0, WIDTH_BYTE, 1, rd, er, lat);
    chk("ld_byte_u", rd, 32'h00000080);
    xact(0, 32'h10, 0, WIDTH_WORD, 0, rd, er, lat);
    chk("ld_word_after_byte", rd, 32'h80ADBEEF);

    // Half store and extensions
    xact(1, 32'h14, 32'h11223344, WIDTH_WORD, 0, rd, er, lat);
    xact(1, 32'h16, 32'hFFFFA5C3, WIDTH_HALF, 0, rd, er, lat);
    xact(0, 32'h14, 0, WIDTH_HALF, 0, rd, er, lat);
    chk("ld_half_lo_s", rd, 32'h00003344);
    xact(0, 32'h16, 0, WIDTH_HALF, 0, rd, er, lat);
    chk("ld_half_hi_s", rd, 32'hFFFFA5C3);
    xact(0, 32'h16, 0, WIDTH_HALF, 1, rd, er, lat);
    chk("ld_half_hi_u", rd, 32'h0000A5C3);
    xact(0, 32'h14, 0, WIDTH_WORD, 0, rd, er, lat);
    chk("ld_word_after_half", rd, 32'hA5C33344);

    // Backpressure, with an ignored request presented during RESP
    xact(1, 32'h20, 32'hCAFEF00D, WIDTH_WORD, 0, rd, er, lat);
    bus.req_we = 0; bus.req_addr = 32'h20; bus.req_lwhb = WIDTH_WORD; bus.req_valid = 1;
    @(posedge clk); #1;
    bus.req_we = 1; bus.req_wdata = 32'h0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
      chk("bp_resp_rdata", bus.resp_rdata, 32'hCAFEF00D);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
      @(posedge clk); #1;
    end
    bus.req_valid = 0;
    bus.resp_ready = 1;
    @(posedge clk); #1;
    bus.resp_ready = 0;
    chk("bp_done_valid", 32'(bus.resp_valid), 32'd0);
    chk("bp_done_ready", 32'(bus.req_ready), 32'd1);
    xact(0, 32'h20, 0, WIDTH_WORD, 0, rd, er, lat);
    chk("bp_ignored_store", rd, 32'hCAFEF00D);

    // Reset in the middle of WAIT aborts the store
    bus.req_we = 1; bus.req_addr = 32'h20; bus.req_wdata = 32'h12345678;
    bus.req_swhb = WIDTH_WORD; bus.req_valid = 1;
    @(posedge clk); #1;
    bus.req_valid = 0;
    chk("mid_wait_ready", 32'(bus.req_ready), 32'd0);
    reset = 1'b0;
    #1;
    chk("abort_req_ready", 32'(bus.req_ready), 32'd1);
    chk("abort_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("abort_resp_rdata", bus.resp_rdata, 32'h0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    xact(0, 32'h20, 0, WIDTH_WORD, 0, rd, er, lat);
    chk("abort_no_write", rd, 32'hCAFEF00D);

    // Misaligned accesses
    xact(1, 32'h24, 32'h01020304, WIDTH_WORD, 0, rd, er, lat);
    xact(0, 32'h22, 0, WIDTH_WORD, 0, rd, er, lat);
`ifdef DMEM_SLAVE_MISALIGN_TRAP_EN
    chk("mis_word_rdata", rd, 32'h0);
    chk("mis_word_err", 32'(er), 32'd1);
`else
    chk("mis_word_rdata", rd, 32'hCAFEF00D);
    chk("mis_word_err", 32'(er), 32'd0);
`endif
    xact(0, 32'h13, 0, WIDTH_HALF, 0, rd, er, lat);
`ifdef DMEM_SLAVE_MISALIGN_TRAP_EN
    chk("mis_half_rdata", rd, 32'h0);
    chk("mis_half_err", 32'(er), 32'd1);
`else
    chk("mis_half_rdata", rd, 32'hFFFF80AD);
    chk("mis_half_err", 32'(er), 32'd0);
`endif
    xact(1, 32'h25, 32'h55667788, WIDTH_WORD, 0, rd, er, lat);
    xact(0, 32'h24, 0, WIDTH_WORD, 0, rd, er, lat);
`ifdef DMEM_SLAVE_MISALIGN_TRAP_EN
    chk("mis_store", rd, 32'h01020304);
`else
    chk("mis_store", rd, 32'h55667788);
`endif

    // Zero-wait instance, address wrap modulo depth
    xact0(1, 32'h1000, 32'h0BADF00D, rd, lat);
    chk("w0_store_lat", 32'(lat), 32'd1);
    xact0(0, 32'h0, 0, rd, lat);
    chk("w0_load_lat", 32'(lat), 32'd1);
    chk("w0_wrap_load", rd, 32'h0BADF00D);

    $display("[TB] %0d tests run, %0d failed", nRun, nFail);
    $finish;
  end

endmodule
